// File: rtl/cycle_mover.sv
// Light-cycle motion and collision controller: advances both heads once per tick,
// checks walls, trails and head contact through the trace memory, then strobes writes or ends the round.
module cycle_mover #(
   parameter int unsigned GRID_W      = 640,
   parameter int unsigned GRID_H      = 480,
   parameter int unsigned TICK_CYCLES = 1_000_000,
   parameter int unsigned START_X1    = 160,
   parameter int unsigned START_Y1    = 240,
   parameter int unsigned START_X2    = 480,
   parameter int unsigned START_Y2    = 240
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] dir1,
   input  logic       dir1_valid,
   input  logic [1:0] dir2,
   input  logic       dir2_valid,
   output logic [9:0] new_x1,
   output logic [9:0] new_y1,
   output logic [9:0] new_x2,
   output logic [9:0] new_y2,
   output logic       en_cond,
   output logic       en_cond2,
   output logic [9:0] qry_x,
   output logic [9:0] qry_y,
   input  logic       qry_hit,
   output logic       crashed1,
   output logic       crashed2,
   output logic       game_over
);
   localparam int unsigned CW    = 10;
   localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_CHK1  = 3'd3;
   localparam logic [2:0] S_CHK2  = 3'd4;
   localparam logic [2:0] S_EVAL  = 3'd5;
   localparam logic [2:0] S_OVER  = 3'd6;

   localparam logic [1:0] D_UP    = 2'b00;
   localparam logic [1:0] D_RIGHT = 2'b01;
   localparam logic [1:0] D_DOWN  = 2'b10;
   localparam logic [1:0] D_LEFT  = 2'b11;

   logic [2:0]       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [1:0]       cur1, cur1_nx, cur2, cur2_nx;
   logic [1:0]       pend1, pend1_nx, pend2, pend2_nx;
   logic [1:0]       pend1_upd, pend2_upd;
   logic [CW-1:0]    nx1, nx1_nx, ny1, ny1_nx, nx2, nx2_nx, ny2, ny2_nx;
   logic             wall1, wall1_nx, wall2, wall2_nx, hit1, hit1_nx;
   logic [CW-1:0]    new_x1_nx, new_y1_nx, new_x2_nx, new_y2_nx, qry_x_nx, qry_y_nx;
   logic             en_cond_nx, en_cond2_nx, crashed1_nx, crashed2_nx, game_over_nx;
   logic [2*CW:0]    step1, step2;
   logic             head_on, swap, crash1, crash2;

   // One grid step in direction d: {off_grid, x', y'}
   function automatic logic [2*CW:0] step_cell(input logic [1:0] d, input logic [CW-1:0] x,
                                               input logic [CW-1:0] y);
      logic          w;
      logic [CW-1:0] sx, sy;
      w  = 1'b0;
      sx = x;
      sy = y;
      case (d)
         D_UP:    begin w = (y == '0);                sy = y - CW'(1); end
         D_RIGHT: begin w = (x == CW'(GRID_W - 1));   sx = x + CW'(1); end
         D_DOWN:  begin w = (y == CW'(GRID_H - 1));   sy = y + CW'(1); end
         default: begin w = (x == '0);                sx = x - CW'(1); end
      endcase
      return {w, sx, sy};
   endfunction

   // A request reversing the current heading is dropped
   assign pend1_upd = (dir1_valid && (dir1 != (cur1 ^ 2'b10))) ? dir1 : pend1;
   assign pend2_upd = (dir2_valid && (dir2 != (cur2 ^ 2'b10))) ? dir2 : pend2;
   assign step1     = step_cell(pend1_upd, new_x1, new_y1);
   assign step2     = step_cell(pend2_upd, new_x2, new_y2);

   assign head_on = (nx1 == nx2) && (ny1 == ny2);
   assign swap    = (nx1 == new_x2) && (ny1 == new_y2) && (nx2 == new_x1) && (ny2 == new_y1);
   assign crash1  = wall1 | hit1 | head_on | swap;
   assign crash2  = wall2 | qry_hit | head_on | swap;

   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      cur1_nx      = cur1;
      cur2_nx      = cur2;
      pend1_nx     = pend1_upd;
      pend2_nx     = pend2_upd;
      nx1_nx       = nx1;
      ny1_nx       = ny1;
      nx2_nx       = nx2;
      ny2_nx       = ny2;
      wall1_nx     = wall1;
      wall2_nx     = wall2;
      hit1_nx      = hit1;
      new_x1_nx    = new_x1;
      new_y1_nx    = new_y1;
      new_x2_nx    = new_x2;
      new_y2_nx    = new_y2;
      qry_x_nx     = qry_x;
      qry_y_nx     = qry_y;
      en_cond_nx   = 1'b0;
      en_cond2_nx  = 1'b0;
      crashed1_nx  = crashed1;
      crashed2_nx  = crashed2;
      game_over_nx = game_over;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx    = S_WRITE;
               en_cond_nx  = 1'b1;
               en_cond2_nx = 1'b1;
            end
         end
         S_WRITE: begin
            state_nx = S_WAIT;
            cnt_nx   = CNT_W'(TICK_CYCLES - 1);
         end
         S_WAIT: begin
            if (cnt == '0) begin
               state_nx                   = S_CHK1;
               cur1_nx                    = pend1_upd;
               cur2_nx                    = pend2_upd;
               {wall1_nx, nx1_nx, ny1_nx} = step1;
               {wall2_nx, nx2_nx, ny2_nx} = step2;
               qry_x_nx                   = step1[2*CW-1:CW];
               qry_y_nx                   = step1[CW-1:0];
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         S_CHK1: begin
            state_nx = S_CHK2;
            qry_x_nx = nx2;
            qry_y_nx = ny2;
         end
         S_CHK2: begin
            state_nx = S_EVAL;
            hit1_nx  = qry_hit;
         end
         S_EVAL: begin
            if (crash1 || crash2) begin
               state_nx     = S_OVER;
               crashed1_nx  = crashed1 | crash1;
               crashed2_nx  = crashed2 | crash2;
               game_over_nx = 1'b1;
            end else begin
               state_nx    = S_WRITE;
               new_x1_nx   = nx1;
               new_y1_nx   = ny1;
               new_x2_nx   = nx2;
               new_y2_nx   = ny2;
               en_cond_nx  = 1'b1;
               en_cond2_nx = 1'b1;
            end
         end
         S_OVER: begin
            if (start) begin
               state_nx     = S_IDLE;
               new_x1_nx    = CW'(START_X1);
               new_y1_nx    = CW'(START_Y1);
               new_x2_nx    = CW'(START_X2);
               new_y2_nx    = CW'(START_Y2);
               cur1_nx      = D_RIGHT;
               cur2_nx      = D_LEFT;
               pend1_nx     = D_RIGHT;
               pend2_nx     = D_LEFT;
               crashed1_nx  = 1'b0;
               crashed2_nx  = 1'b0;
               game_over_nx = 1'b0;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= '0;
         cur1      <= D_RIGHT;
         cur2      <= D_LEFT;
         pend1     <= D_RIGHT;
         pend2     <= D_LEFT;
         nx1       <= '0;
         ny1       <= '0;
         nx2       <= '0;
         ny2       <= '0;
         wall1     <= 1'b0;
         wall2     <= 1'b0;
         hit1      <= 1'b0;
         new_x1    <= CW'(START_X1);
         new_y1    <= CW'(START_Y1);
         new_x2    <= CW'(START_X2);
         new_y2    <= CW'(START_Y2);
         qry_x     <= '0;
         qry_y     <= '0;
         en_cond   <= 1'b0;
         en_cond2  <= 1'b0;
         crashed1  <= 1'b0;
         crashed2  <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         cur1      <= cur1_nx;
         cur2      <= cur2_nx;
         pend1     <= pend1_nx;
         pend2     <= pend2_nx;
         nx1       <= nx1_nx;
         ny1       <= ny1_nx;
         nx2       <= nx2_nx;
         ny2       <= ny2_nx;
         wall1     <= wall1_nx;
         wall2     <= wall2_nx;
         hit1      <= hit1_nx;
         new_x1    <= new_x1_nx;
         new_y1    <= new_y1_nx;
         new_x2    <= new_x2_nx;
         new_y2    <= new_y2_nx;
         qry_x     <= qry_x_nx;
         qry_y     <= qry_y_nx;
         en_cond   <= en_cond_nx;
         en_cond2  <= en_cond2_nx;
         crashed1  <= crashed1_nx;
         crashed2  <= crashed2_nx;
         game_over <= game_over_nx;
      end
   end

endmodule

// File: tb/tb_cycle_mover.sv
// Bench for cycle_mover: step-level game model with its own trail grid acting as the trace memory.
module tb_cycle_mover;
   localparam int TICK = 8;
   localparam int GW   = 640;
   localparam int GH   = 480;
   localparam int SX1  = 160;
   localparam int SY1  = 240;
   localparam int SX2  = 480;
   localparam int SY2  = 240;

   logic       clock = 1'b0;
   logic       reset, start, dir1_valid, dir2_valid, qry_hit;
   logic [1:0] dir1, dir2;
   logic [9:0] new_x1, new_y1, new_x2, new_y2, qry_x, qry_y;
   logic       en_cond, en_cond2, crashed1, crashed2, game_over;

   cycle_mover #(
      .GRID_W(GW), .GRID_H(GH), .TICK_CYCLES(TICK),
      .START_X1(SX1), .START_Y1(SY1), .START_X2(SX2), .START_Y2(SY2)
   ) dut (
      .clock(clock), .reset(reset), .start(start),
      .dir1(dir1), .dir1_valid(dir1_valid), .dir2(dir2), .dir2_valid(dir2_valid),
      .new_x1(new_x1), .new_y1(new_y1), .new_x2(new_x2), .new_y2(new_y2),
      .en_cond(en_cond), .en_cond2(en_cond2), .qry_x(qry_x), .qry_y(qry_y),
      .qry_hit(qry_hit), .crashed1(crashed1), .crashed2(crashed2), .game_over(game_over)
   );

   always #5 clock = ~clock;

   int         total = 0;
   int         bad   = 0;
   bit         grid [0:GW-1][0:GH-1];
   int         hx1, hy1, hx2, hy2;
   logic [1:0] cur1, cur2, pend1, pend2;
   int         mode, step_no;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   function automatic logic [1:0] opposite(input logic [1:0] d);
      case (d)
         2'b00:   return 2'b10;
         2'b01:   return 2'b11;
         2'b10:   return 2'b00;
         default: return 2'b01;
      endcase
   endfunction

   task automatic move(input logic [1:0] d, input int x, input int y,
                       output int nx, output int ny, output bit w);
      nx = x;
      ny = y;
      w  = 1'b0;
      case (d)
         2'b00:   begin ny = y - 1; w = (y == 0);      end
         2'b01:   begin nx = x + 1; w = (x == GW - 1); end
         2'b10:   begin ny = y + 1; w = (y == GH - 1); end
         default: begin nx = x - 1; w = (x == 0);      end
      endcase
   endtask

   task automatic model_idle();
      hx1 = SX1; hy1 = SY1; hx2 = SX2; hy2 = SY2;
      cur1 = 2'b01; cur2 = 2'b11; pend1 = 2'b01; pend2 = 2'b11;
   endtask

   task automatic clear_grid();
      for (int x = 0; x < GW; x++)
         for (int y = 0; y < GH; y++)
            grid[x][y] = 1'b0;
   endtask

   task automatic quiet();
      dir1_valid = 1'b0;
      dir2_valid = 1'b0;
      start      = 1'b0;
      qry_hit    = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_x1"}, 32'(new_x1), SX1);
      check({tag, "_y1"}, 32'(new_y1), SY1);
      check({tag, "_x2"}, 32'(new_x2), SX2);
      check({tag, "_y2"}, 32'(new_y2), SY2);
      check({tag, "_en1"}, 32'(en_cond), 0);
      check({tag, "_en2"}, 32'(en_cond2), 0);
      check({tag, "_c1"}, 32'(crashed1), 0);
      check({tag, "_c2"}, 32'(crashed2), 0);
      check({tag, "_over"}, 32'(game_over), 0);
      check({tag, "_qx"}, 32'(qry_x), 0);
      check({tag, "_qy"}, 32'(qry_y), 0);
   endtask

   // Drive this cycle's direction requests and fold them into the pending model
   task automatic drive_dirs(input int p);
      bit         v1, v2;
      logic [1:0] d1, d2;
      v1 = 1'b0;
      v2 = 1'b0;
      d1 = 2'($urandom_range(0, 3));
      d2 = 2'($urandom_range(0, 3));
      case (mode)
         1: begin
            v1    = ($urandom_range(0, 4) == 0);
            v2    = ($urandom_range(0, 4) == 0);
            start = ($urandom_range(0, 7) == 0);
         end
         2: begin
            if (step_no == 1 && p < 3) begin
               v1 = 1'b1;
               d1 = (p == 0) ? 2'b11 : ((p == 1) ? 2'b00 : 2'b10);
            end else if (step_no == 2 && p == TICK) begin
               v1 = 1'b1;
               d1 = 2'b00;
            end else if (step_no >= 3) begin
               v1 = ($urandom_range(0, 4) == 0);
               v2 = ($urandom_range(0, 4) == 0);
            end
         end
         3: begin
            if (step_no == 0 && p == 0) begin
               v1 = 1'b1;
               d1 = 2'b00;
            end
         end
         default: ;
      endcase
      dir1_valid = v1;
      dir1       = d1;
      dir2_valid = v2;
      dir2       = d2;
      if (v1 && d1 != opposite(cur1)) pend1 = d1;
      if (v2 && d2 != opposite(cur2)) pend2 = d2;
   endtask

   // Entered with the WRITE cycle visible; leaves with the next WRITE or OVER cycle visible
   task automatic run_step(output bit ended);
      int n1x, n1y, n2x, n2y;
      bit w1, w2, h1, h2, c1, c2, meet, swp, force_h2;
      check("strobe1", 32'(en_cond), 1);
      check("strobe2", 32'(en_cond2), 1);
      check("head_x1", 32'(new_x1), hx1);
      check("head_y1", 32'(new_y1), hy1);
      check("head_x2", 32'(new_x2), hx2);
      check("head_y2", 32'(new_y2), hy2);
      grid[hx1][hy1] = 1'b1;
      grid[hx2][hy2] = 1'b1;
      qry_hit = 1'b0;
      for (int p = 0; p <= TICK; p++) begin
         if (p == 1) begin
            check("strobe1_width", 32'(en_cond), 0);
            check("strobe2_width", 32'(en_cond2), 0);
         end
         drive_dirs(p);
         if (p == TICK) begin
            cur1 = pend1;
            cur2 = pend2;
         end
         tick();
      end
      move(cur1, hx1, hy1, n1x, n1y, w1);
      move(cur2, hx2, hy2, n2x, n2y, w2);
      if (!w1) begin
         check("qry_x1", 32'(qry_x), n1x);
         check("qry_y1", 32'(qry_y), n1y);
      end
      qry_hit = 1'($urandom_range(0, 1));
      drive_dirs(TICK + 1);
      tick();
      if (!w2) begin
         check("qry_x2", 32'(qry_x), n2x);
         check("qry_y2", 32'(qry_y), n2y);
      end
      h1 = 1'b0;
      if (!w1) h1 = grid[n1x][n1y];
      qry_hit = w1 ? 1'($urandom_range(0, 1)) : h1;
      drive_dirs(TICK + 2);
      tick();
      force_h2 = (mode == 1 || mode == 2) && (step_no == 30);
      h2 = 1'b0;
      if (!w2) h2 = grid[n2x][n2y] || force_h2;
      qry_hit = w2 ? 1'($urandom_range(0, 1)) : h2;
      drive_dirs(TICK + 3);
      tick();
      quiet();
      meet  = (n1x == n2x) && (n1y == n2y);
      swp   = (n1x == hx2) && (n1y == hy2) && (n2x == hx1) && (n2y == hy1);
      c1    = w1 | h1 | meet | swp;
      c2    = w2 | h2 | meet | swp;
      ended = c1 | c2;
      if (ended) begin
         check("over", 32'(game_over), 1);
         check("crash1", 32'(crashed1), 32'(c1));
         check("crash2", 32'(crashed2), 32'(c2));
         check("over_no_strobe1", 32'(en_cond), 0);
         check("over_no_strobe2", 32'(en_cond2), 0);
         check("over_hold_x1", 32'(new_x1), hx1);
         check("over_hold_x2", 32'(new_x2), hx2);
      end else begin
         hx1 = n1x; hy1 = n1y; hx2 = n2x; hy2 = n2y;
      end
      step_no++;
   endtask

   task automatic run_round(input int m);
      bit ended;
      mode    = m;
      step_no = 0;
      ended   = 1'b0;
      clear_grid();
      quiet();
      start = 1'b1;
      tick();
      start = 1'b0;
      while (!ended && step_no < 400) run_step(ended);
      if (!ended) check("round_end", 0, 1);
   endtask

   task automatic restart();
      quiet();
      start = 1'b1;
      tick();
      start = 1'b0;
      model_idle();
      check("restart_over", 32'(game_over), 0);
      check("restart_c1", 32'(crashed1), 0);
      check("restart_c2", 32'(crashed2), 0);
      check("restart_x1", 32'(new_x1), SX1);
      check("restart_y1", 32'(new_y1), SY1);
      check("restart_x2", 32'(new_x2), SX2);
      check("restart_y2", 32'(new_y2), SY2);
      check("restart_en", 32'(en_cond), 0);
   endtask

   initial begin
      reset = 1'b1;
      quiet();
      dir1 = 2'b00;
      dir2 = 2'b00;
      model_idle();
      repeat (2) @(negedge clock);
      check_reset_vals("rst");
      reset = 1'b0;
      tick();
      check_reset_vals("idle");

      run_round(2);
      restart();

      run_round(3);
      check("wall_c1", 32'(crashed1), 1);
      check("wall_c2", 32'(crashed2), 0);
      check("wall_y1", 32'(new_y1), 0);
      restart();

      run_round(0);
      check("headon_c1", 32'(crashed1), 1);
      check("headon_c2", 32'(crashed2), 1);
      check("headon_x1", 32'(new_x1), 319);
      check("headon_x2", 32'(new_x2), 321);
      restart();

      for (int r = 0; r < 3; r++) begin
         run_round(1);
         restart();
      end

      // Asynchronous reset landing in CHK2
      mode    = 0;
      step_no = 0;
      start   = 1'b1;
      tick();
      start = 1'b0;
      repeat (TICK + 2) tick();
      check("chk2_qx", 32'(qry_x), SX2 - 1);
      check("chk2_qy", 32'(qry_y), SY2);
      #2 reset = 1'b1;
      #1 check_reset_vals("async");
      @(negedge clock);
      reset = 1'b0;
      model_idle();
      repeat (3) tick();
      check("post_rst_over", 32'(game_over), 0);
      check("post_rst_en", 32'(en_cond), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cycle_mover.md
# cycle_mover

Light-cycle motion and collision controller for the two-player Tron game. On each movement tick it advances both heads one grid cell in their current directions and checks walls, trails and head-to-head contact through a one-cycle-latency read port on the trace memory. It then either emits head coordinates with write strobes to the trace-drawing stage (`new_x1/new_y1/new_x2/new_y2/en_cond`) or ends the round. The trace-drawing stage sits directly downstream and marks the written cells in `grid_mem`.

## Interface
Parameters:
- `GRID_W`, 640: columns; legal x is 0..GRID_W-1.
- `GRID_H`, 480: rows; legal y is 0..GRID_H-1.
- `TICK_CYCLES`, 1_000_000: clock cycles per movement step, minimum 8.
- `START_X1`, `START_Y1`, 160, 240: player 1 spawn cell.
- `START_X2`, `START_Y2`, 480, 240: player 2 spawn cell.

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: level-sampled; begins a round from IDLE or OVER.
- `dir1` in 2: player 1 requested direction (00 up, 01 right, 10 down, 11 left).
- `dir1_valid` in 1: `dir1` is sampled this cycle.
- `dir2` in 2: player 2 requested direction, same encoding as `dir1`.
- `dir2_valid` in 1: `dir2` is sampled this cycle.
- `new_x1`, `new_y1` out 10: player 1 head cell.
- `new_x2`, `new_y2` out 10: player 2 head cell.
- `en_cond` out 1: write strobe for player 1 head.
- `en_cond2` out 1: write strobe for player 2 head.
- `qry_x`, `qry_y` out 10: trace memory query address.
- `qry_hit` in 1: trace bit for the address presented the previous cycle.
- `crashed1`, `crashed2` out 1: sticky crash flags for the round.
- `game_over` out 1: high in OVER.

## Operation
- **States:** IDLE, WRITE, WAIT, CHK1, CHK2, EVAL, OVER.
- **IDLE:**
  - Heads are held at the spawn cells.
  - `dir_cur1` = right and `dir_cur2` = left.
  - On `start`, go to WRITE so the spawn cells are marked.
- **WRITE:** one cycle, `en_cond` = `en_cond2` = 1, then WAIT with the tick counter loaded to TICK_CYCLES-1.
- **WAIT:**
  - The counter decrements each cycle.
  - At 0, go to CHK1 and latch `pend1`/`pend2` into `dir_cur1`/`dir_cur2`.
  - Compute `next1` and `next2`: up is y-1, down is y+1, left is x-1, right is x+1.
- **Direction requests:**
  - Each `dirN_valid` cycle in any state writes `pendN`, except a request opposite to `dir_curN`, which is ignored.
  - The last accepted request before the tick wins.
  - `pendN` resets to `dir_curN` on entry to IDLE.
- **Wall detection:**
  - A step off the grid (x=0 moving left, x=GRID_W-1 moving right, y=0 moving up, y=GRID_H-1 moving down) sets `wallN`.
  - There is no wrap-around.
  - The `next` value for a wall step is don't-care, and the query result for it is ignored.
- **CHK1:** `qry` = `next1`.
- **CHK2:** `qry` = `next2`; sample `qry_hit` as `hit1`.
- **EVAL:** sample `qry_hit` as `hit2`, then:
  - `crash1` = `wall1` | `hit1` | head-on | swap.
  - `crash2` = `wall2` | `hit2` | head-on | swap.
  - Head-on means `next1` == `next2`.
  - Swap means `next1` == `head2` and `next2` == `head1`.
  - If either crashes, set the sticky flags and go to OVER. The heads are not updated and there is no write.
  - Otherwise load the heads with `next1`/`next2` and go to WRITE.
- **OVER:** `game_over` = 1, outputs are held.
  - `start` → IDLE; this restores spawn positions and clears `crashed1`/`crashed2`.
  - Clearing `grid_mem` is outside this block.
- **`start` while running:** ignored.
- **Reset at any time:** forces IDLE state values immediately, including mid-check.

## Timing
- **Reset values:**
  - `new_x1`/`new_y1` = START_X1/START_Y1; `new_x2`/`new_y2` = START_X2/START_Y2.
  - `en_cond`, `en_cond2`, `crashed1`, `crashed2` and `game_over` = 0.
  - `qry_x`/`qry_y` = 0.
- **Registered outputs:** all outputs are registered. `new_*` change only in the cycle that WRITE is entered, and are stable while `en_cond`/`en_cond2` are high.
- **Step period:** WRITE, TICK_CYCLES cycles of WAIT, then CHK1, CHK2, EVAL, for TICK_CYCLES+4 cycles in total. The strobes are exactly one cycle wide.
- **Query latency:** `qry_x/qry_y` registered at cycle n gives `qry_hit` valid at cycle n+1.
- **Crash latency:** `crashed*` and `game_over` rise on the cycle after EVAL.
- **Direction capture:** a direction accepted in the final WAIT cycle is applied to that step.

## Test plan
- **Spawn:** reset, then `start` → one `en_cond`/`en_cond2` pulse with heads (160,240)/(480,240); after TICK_CYCLES+4 cycles, heads are (161,240)/(479,240).
- **Reverse reject:** P1 moving right, `dir1`=11 valid → ignored; `dir1`=00 then 10 within one tick → P1 moves down (y+1).
- **Wall:** START_X1=GRID_W-1 moving right → `crashed1`=1, `crashed2`=0, `game_over`=1, no strobe.
- **Trail hit:** drive `qry_hit`=1 only during the cycle after CHK2 (the `hit2` sample) → `crashed2`=1 only; heads are unchanged.
- **Head-on:** spawns (100,50) and (102,50) facing each other → both heads target (101,50), and both crash flags are set.
- **Restart and reset:** `start` in OVER → IDLE with spawn heads and flags cleared; reset asserted during CHK2 → all outputs return to reset values asynchronously.
